// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: dual-lane retire FIFO feeding one regfile write port.
// Optional WB_FWD_EN adds two combinational lookup ports over queued writes.
module regfile_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         a_valid,
  input  logic [ADDR_WIDTH-1:0]        a_addr,
  input  logic [DATA_WIDTH-1:0]        a_data,
  input  logic                         b_valid,
  input  logic [ADDR_WIDTH-1:0]        b_addr,
  input  logic [DATA_WIDTH-1:0]        b_data,
  output logic                         in_ready,
  output logic                         wb_we,
  output logic [ADDR_WIDTH-1:0]        wb_addr,
  output logic [DATA_WIDTH-1:0]        wb_data,
  output logic [$clog2(DEPTH+1)-1:0]   pending_cnt
`ifdef WB_FWD_EN
  ,
  input  logic [ADDR_WIDTH-1:0]        fwd_addr0,
  input  logic [ADDR_WIDTH-1:0]        fwd_addr1,
  output logic                         fwd_hit0,
  output logic                         fwd_hit1,
  output logic [DATA_WIDTH-1:0]        fwd_data0,
  output logic [DATA_WIDTH-1:0]        fwd_data1
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [CW-1:0]         count;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         b_slot;
  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic                  a_push;
  logic                  b_push;
  logic                  pop;
  logic [1:0]            n_push;

  // Two free slots are always kept when accepting, so a pair never overflows.
  assign in_ready = (count <= CW'(DEPTH-2));

  // Lane A is dropped when B targets the same register (younger wins).
  assign a_push = in_ready && a_valid
               && (a_addr != '0)
               && !(b_valid && (b_addr == a_addr));
  assign b_push = in_ready && b_valid && (b_addr != '0);

  assign pop    = (count != '0);
  assign n_push = {1'b0, a_push} + {1'b0, b_push};
  assign b_slot = wr_ptr + PW'(a_push);

  assign pending_cnt = count;

  // Entry storage: A lands first, B directly behind it.
  always_ff @(posedge clk) begin
    if (a_push) begin
      mem_addr[wr_ptr] <= a_addr;
      mem_data[wr_ptr] <= a_data;
    end
    if (b_push) begin
      mem_addr[b_slot] <= b_addr;
      mem_data[b_slot] <= b_data;
    end
  end

  // Pointers, occupancy and the registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      count  <= count + CW'(n_push) - CW'(pop);
      wr_ptr <= wr_ptr + PW'(n_push);
      rd_ptr <= rd_ptr + PW'(pop);
      wb_we  <= pop;
      if (pop) begin
        wb_addr <= mem_addr[rd_ptr];
        wb_data <= mem_data[rd_ptr];
      end
    end
  end

`ifdef WB_FWD_EN
  logic [ADDR_WIDTH-1:0] lk_addr [2];

  assign lk_addr[0] = fwd_addr0;
  assign lk_addr[1] = fwd_addr1;

  for (genvar p = 0; p < 2; p++) begin : g_fwd
    logic                  hit;
    logic [DATA_WIDTH-1:0] data;

    // Output stage first, then FIFO oldest to youngest so younger overrides.
    always_comb begin
      hit  = 1'b0;
      data = '0;
      if (lk_addr[p] != '0) begin
        if (wb_we && (wb_addr == lk_addr[p])) begin
          hit  = 1'b1;
          data = wb_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if ((CW'(i) < count)
              && (mem_addr[rd_ptr + PW'(i)] == lk_addr[p])) begin
            hit  = 1'b1;
            data = mem_data[rd_ptr + PW'(i)];
          end
        end
      end
    end
  end

  assign fwd_hit0  = g_fwd[0].hit;
  assign fwd_hit1  = g_fwd[1].hit;
  assign fwd_data0 = g_fwd[0].data;
  assign fwd_data1 = g_fwd[1].data;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: scoreboard of expected regfile writes.
// Build with WB_FWD_EN defined to also exercise the lookup ports.
module tb_regfile_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_valid = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_data = '0;
  logic          b_valid = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_data = '0;
  logic          in_ready;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [2:0]    pending_cnt;
`ifdef WB_FWD_EN
  logic [AW-1:0] fwd_addr0 = '0;
  logic [AW-1:0] fwd_addr1 = '0;
  logic          fwd_hit0;
  logic          fwd_hit1;
  logic [DW-1:0] fwd_data0;
  logic [DW-1:0] fwd_data1;
`endif

  regfile_wb_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data),
    .in_ready(in_ready),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .pending_cnt(pending_cnt)
`ifdef WB_FWD_EN
    ,
    .fwd_addr0(fwd_addr0), .fwd_addr1(fwd_addr1),
    .fwd_hit0(fwd_hit0), .fwd_hit1(fwd_hit1),
    .fwd_data0(fwd_data0), .fwd_data1(fwd_data1)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  stalls = 0;

  // Every write seen on the port must be the next expected one.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && wb_we === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got x%0d=%h, required no write",
                 wb_addr, wb_data);
      end else begin
        e = sb.pop_front();
        if (wb_addr !== e.a || wb_data !== e.d) begin
          errors++;
          $display("FAIL wb_order: got x%0d=%h, required x%0d=%h",
                   wb_addr, wb_data, e.a, e.d);
        end
      end
    end
  end

  task automatic send(input logic av, input logic [AW-1:0] aa,
                      input logic [DW-1:0] ad, input logic bv,
                      input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    int  n;
    bit  ok;
    wr_t e;
    n  = 0;
    ok = 0;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    while (!ok && n < 20) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1;
        if (av && aa != '0 && !(bv && ba == aa)) begin
          e.a = aa; e.d = ad; sb.push_back(e);
        end
        if (bv && ba != '0) begin
          e.a = ba; e.d = bd; sb.push_back(e);
        end
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=%b, required 1", in_ready);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic drain_wait();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d writes missing, required 0", sb.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if (wb_we !== 1'b0 || in_ready !== 1'b1 || pending_cnt !== 3'd0) begin
        errors++;
        $display("FAIL reset_hold: got we=%b rdy=%b cnt=%0d, required 0 1 0",
                 wb_we, in_ready, pending_cnt);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if (wb_we !== 1'b0 || in_ready !== 1'b1 || pending_cnt !== 3'd0) begin
        errors++;
        $display("FAIL reset_idle: got we=%b rdy=%b cnt=%0d, required 0 1 0",
                 wb_we, in_ready, pending_cnt);
      end
    end
  endtask

  task automatic test_single();
    send(1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 32'h0);
    checks++;
    if (wb_we !== 1'b0 || pending_cnt !== 3'd1) begin
      errors++;
      $display("FAIL single_queued: got we=%b cnt=%0d, required 0 1",
               wb_we, pending_cnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (wb_we !== 1'b1 || wb_addr !== 5'd5 || wb_data !== 32'h1234) begin
      errors++;
      $display("FAIL single_write: got we=%b x%0d=%h, required 1 x5=1234",
               wb_we, wb_addr, wb_data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (wb_we !== 1'b0 || pending_cnt !== 3'd0) begin
      errors++;
      $display("FAIL single_once: got we=%b cnt=%0d, required 0 0",
               wb_we, pending_cnt);
    end
    drain_wait();
  endtask

  task automatic test_squash();
    send(1'b1, 5'd7, 32'hAAAA, 1'b1, 5'd7, 32'hBBBB);
    checks++;
    if (pending_cnt !== 3'd1) begin
      errors++;
      $display("FAIL squash_cnt: got %0d, required 1", pending_cnt);
    end
    send(1'b1, 5'd0, 32'h1, 1'b1, 5'd3, 32'h3);
    checks++;
    if (pending_cnt !== 3'd1) begin
      errors++;
      $display("FAIL x0_cnt: got %0d, required 1", pending_cnt);
    end
    drain_wait();
  endtask

  task automatic test_back_pressure();
    stalls = 0;
    for (int k = 0; k < 4; k++) begin
      send(1'b1, AW'(8 + 2 * k), DW'(32'hA0 + k),
           1'b1, AW'(9 + 2 * k), DW'(32'hB0 + k));
      if (k == 1) begin
        checks++;
        if (in_ready !== 1'b0 || pending_cnt !== 3'd3) begin
          errors++;
          $display("FAIL bp_full: got rdy=%b cnt=%0d, required 0 3",
                   in_ready, pending_cnt);
        end
      end
    end
    checks++;
    if (stalls != 2) begin
      errors++;
      $display("FAIL bp_stalls: got %0d, required 2", stalls);
    end
    drain_wait();
  endtask

  task automatic test_back_to_back_reset();
    bit seen;
    seen = 0;
    send(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    send(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    checks++;
    if (pending_cnt !== 3'd3) begin
      errors++;
      $display("FAIL mid_fill: got %0d, required 3", pending_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    checks++;
    if (wb_we !== 1'b0 || pending_cnt !== 3'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got we=%b cnt=%0d rdy=%b, required 0 0 1",
               wb_we, pending_cnt, in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (wb_we !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_discard: got write after reset, required none");
    end
  endtask

`ifdef WB_FWD_EN
  task automatic test_fwd();
    fwd_addr0 = 5'd9;
    fwd_addr1 = 5'd0;
    send(1'b1, 5'd9, 32'h11, 1'b0, 5'd0, 32'h0);
    send(1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 32'h0);
    checks++;
    if (fwd_hit0 !== 1'b1 || fwd_data0 !== 32'h22) begin
      errors++;
      $display("FAIL fwd_young: got hit=%b d=%h, required 1 22",
               fwd_hit0, fwd_data0);
    end
    checks++;
    if (fwd_hit1 !== 1'b0 || fwd_data1 !== 32'h0) begin
      errors++;
      $display("FAIL fwd_x0: got hit=%b d=%h, required 0 0",
               fwd_hit1, fwd_data1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (fwd_hit0 !== 1'b1 || fwd_data0 !== 32'h22) begin
      errors++;
      $display("FAIL fwd_stage: got hit=%b d=%h, required 1 22",
               fwd_hit0, fwd_data0);
    end
    drain_wait();
    checks++;
    if (fwd_hit0 !== 1'b0 || fwd_data0 !== 32'h0) begin
      errors++;
      $display("FAIL fwd_miss: got hit=%b d=%h, required 0 0",
               fwd_hit0, fwd_data0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_squash();
    test_back_pressure();
    test_back_to_back_reset();
`ifdef WB_FWD_EN
    test_fwd();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-side feeder for the dual-issue core's 32x32 register file.
- Accepts up to two retiring results per cycle (lane A = older, lane B = younger), queues them in a small in-order FIFO, and drives exactly one register-file write port per cycle.
- Also removes same-cycle same-destination conflicts between the two lanes.
- Sits between the two execute/writeback stages and the register file write port (WE, ADDR, WD).

Parameters:
- ADDR_WIDTH, 5, register index width.
- DATA_WIDTH, 32, register data width.
- DEPTH, 4, FIFO entries; power of 2, >= 2.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  lane A result valid.
- a_addr  input  ADDR_WIDTH  lane A destination register.
- a_data  input  DATA_WIDTH  lane A result.
- b_valid  input  1  lane B result valid.
- b_addr  input  ADDR_WIDTH  lane B destination register.
- b_data  input  DATA_WIDTH  lane B result.
- in_ready  output  1  both lanes may present results this cycle.
- wb_we  output  1  register-file write enable.
- wb_addr  output  ADDR_WIDTH  register-file write address.
- wb_data  output  DATA_WIDTH  register-file write data.
- pending_cnt  output  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (asynchronous, rst_n=0): count=0, read/write pointers=0, wb_we=0, wb_addr=0, wb_data=0; hence in_ready=1, pending_cnt=0. Reset mid-operation discards all queued entries with no further writes.
- in_ready = (count <= DEPTH-2). Combinational from the registered count only; a same-cycle pop does not credit it.
- Acceptance at a rising edge requires in_ready=1. Lane valids seen while in_ready=0 are ignored; no state change. Upstream holds its results.
- Address 0 filtering: a lane with addr==0 is accepted but not enqueued.
- Same-destination squash: if both lanes are valid with a_addr==b_addr!=0, only lane B is enqueued (younger wins).
- Enqueue order: lane A then lane B, so 0, 1 or 2 pushes per edge. Write pointer advances by the push count, wrapping modulo DEPTH.
- Drain: at each rising edge with count>0, head entry -> wb_we=1, wb_addr, wb_data (registered outputs); read pointer advances by 1. With count==0: wb_we=0, and wb_addr/wb_data hold their last values.
- Count update: count_next = count + pushes - pop. A simultaneous push and pop on a full-boundary edge is legal.
- Latency: result sampled at edge N into an empty FIFO -> wb_we=1 between edges N+1 and N+2. The register file commits it on that cycle's falling edge.
- wb_we is never high for two entries in the same cycle. Order on the write port equals program order: A before B, earlier cycles first.
- Invariants:
  - Overflow is impossible because in_ready guarantees 2 free slots.
  - Underflow is impossible because a pop occurs only when count>0.

Optional Feature:
- Macro WB_FWD_EN.
- When defined, adds ports:
  - fwd_addr0, fwd_addr1 (input, ADDR_WIDTH).
  - fwd_hit0, fwd_hit1 (output, 1).
  - fwd_data0, fwd_data1 (output, DATA_WIDTH).
- Each lookup is purely combinational and searches the valid FIFO entries plus the current wb_* output stage. Priority: youngest FIFO entry > older FIFO entries > output stage (wb_we=1 only).
- Address 0 never hits. On a miss, fwd_hit=0 and fwd_data=0.
- When undefined, these ports and the search logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then high -> wb_we=0, in_ready=1, pending_cnt=0 throughout.
- Single write: lane A x5=0x0000_1234 at edge N -> wb_we=1, wb_addr=5, wb_data=0x1234 for exactly one cycle after edge N+1.
- Dual write with squash and x0:
  - Edge N: A x7=0xAAAA, B x7=0xBBBB -> one write, x7=0xBBBB.
  - Edge N+1: A x0=0x1, B x3=0x3 -> only the x3 write appears.
- Back-pressure: both lanes valid with distinct nonzero addresses on 4 consecutive edges (DEPTH=4) -> in_ready drops when count reaches 3. Held results are accepted later. All 8 writes appear in order A0,B0,A1,B1,… with no loss or duplication.
- Reset mid-drain: assert rst_n=0 with pending_cnt=3 -> wb_we=0 immediately (asynchronous) and no queued write appears after release.
- WB_FWD_EN: queue x9=0x11 then x9=0x22, with fwd_addr0=9 before the drain -> fwd_hit0=1, fwd_data0=0x22. With fwd_addr1=0 -> fwd_hit1=0.
